pipe_decode_stage: RTL and testbench
====================================

PIPE_DECODE_STAGE -- requirements
Module: pipe_decode_stage

Interface
REQ-001 Parameters SHALL be:
- XLEN, default 32, datapath width (>=32).
- NREG, default 32, register count (power of 2, <=32).
- CW, default 16, hazard-counter width.
REQ-002 Reset SHALL be rst, asynchronous, active-high; the clock SHALL be clk.
REQ-003 Ports SHALL be, in order (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  reset
- if_valid  in  1  instruction present
- if_pc  in  XLEN  instruction address
- if_ir  in  32  instruction
- id_ready  out  1  stage accepts if_ir this cycle
- ex_stall  in  1  downstream holds DX register
- flush  in  1  discard instruction entering DX
- wb_we  in  1  writeback enable
- wb_rd  in  5  writeback index
- wb_data  in  XLEN  writeback value
- dx_valid  out  1  DX holds real instruction
- dx_memtoreg, dx_regwrite, dx_memread, dx_memwrite, dx_branch, dx_jump  out  1 each  control
- dx_aluctr  out  3  0 add, 1 sub, 2 and, 3 or, 4 slt, 5 compare/none
- dx_a, dx_b, dx_imm, dx_pc, dx_jt  out  XLEN  operands, sign-extended immediate, PC, jump target
- dx_rd, dx_rt  out  5  destination and rt index
- illegal  out  1  one-cycle pulse on an undefined opcode/funct
- hz_count  out  CW  load-use stall count

Function
REQ-004 Decode SHALL be R-type (op 0, funct 32/34/36/37/42 gives aluctr 0/1/2/3/4; funct 8 jr gives jump=1, jt=rs value, aluctr 5), lw 35, sw 43, beq 4 (branch=1, aluctr 5), j 2, and jal 3.
REQ-005 lw SHALL set memread, memtoreg and regwrite with rd=rt. sw SHALL set memwrite. lw and sw SHALL set dx_b to the sign-extended imm and aluctr to 0.
REQ-006 j and jal SHALL set jt={pc[XLEN-1:XLEN-4], ir[25:0], 2'b00} with the middle bits zero-filled when XLEN>32.
REQ-007 jal SHALL set regwrite=1, rd=NREG-1, dx_a=if_pc+4 and dx_b=0; the link is written only through writeback.
REQ-008 Latency SHALL be 1 cycle: an instruction accepted at edge N is presented on dx_* after edge N.
REQ-009 Register reads SHALL return 0 for index 0. A read SHALL return wb_data when wb_we=1, wb_rd equals the index, and the index is nonzero (same-cycle bypass).
REQ-010 A write to index 0 SHALL be ignored. Index bits at or above log2(NREG) SHALL be ignored.
REQ-011 A load-use hazard SHALL exist when all of the following hold:
- dx_valid=1 and dx_memread=1;
- dx_rd is nonzero;
- dx_rd equals the incoming rs, or equals rt for R-type, beq or sw.
REQ-012 On a hazard: id_ready=0, DX SHALL load a bubble (dx_valid=0, all control bits 0), and hz_count SHALL increment, saturating at 2^CW-1.
REQ-013 When ex_stall=1 and flush=0, all dx_* SHALL hold and id_ready SHALL be 0.
REQ-014 When flush=1, DX SHALL load a bubble regardless of ex_stall or a hazard, and id_ready SHALL be 1; the flushed instruction is discarded.
REQ-015 DX update priority SHALL be flush > ex_stall > hazard > normal decode.
REQ-016 When if_valid=0, DX SHALL load a bubble.
REQ-017 An undefined opcode or funct with if_valid=1 SHALL load a bubble and pulse illegal for 1 cycle.
REQ-018 Register-file writes SHALL occur every cycle that wb_we=1, independent of stall and flush.

Reset
REQ-019 rst SHALL clear every dx_* output, illegal and hz_count to 0 on assertion, with no clock needed.
REQ-020 Register-file contents SHALL NOT be reset; reads of index 0 SHALL still return 0.
REQ-021 An instruction in flight when rst asserts SHALL be lost, and dx_valid SHALL be 0 on the first cycle after release.

Structure
REQ-022 Opcode and funct constants, ALU control encodings and the default parameter values SHALL reside in shared package mips_pkg.
REQ-023 The register file (NREG x XLEN, two read ports, one write port, bypass) SHALL be sub-module reg_file_2r1w. Decode, hazard logic and the DX register SHALL reside in pipe_decode_stage.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- add r3,r1,r2 with r1=5, r2=7 -> next cycle dx_aluctr=0, dx_a=5, dx_b=7, dx_rd=3, dx_regwrite=1.
- lw r4,8(r1) followed by add r5,r4,r2 -> one bubble, id_ready=0 for 1 cycle, hz_count=1, then add issues with dx_a sourced correctly.
- wb_we=1, wb_rd=2, wb_data=0xAA while sub r6,r2,r0 decodes -> dx_a=0xAA, dx_b=0.
- ex_stall=1 for 3 cycles during beq -> dx_* held constant, id_ready=0; flush=1 in stall cycle 2 -> dx_valid=0 next cycle.
- jal with if_pc=0x0040_0010, target field 0x100 -> dx_jt=0x0000_0400, dx_a=0x0040_0014, dx_rd=31, dx_jump=1.
- opcode 0x3F -> illegal=1 for 1 cycle, dx_valid=0. rst asserted mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared constants for the MIPS-subset decode stage: default parameter
// values, opcode and funct encodings, the ALU control encoding and the
// control-bit bundle carried in the decode/execute (DX) register.
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int NREG_DEFAULT = 32;
    localparam int CW_DEFAULT   = 16;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_JR  = 6'd8;
    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_SLT = 6'd42;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_SLT  = 3'd4,
        ALU_NONE = 3'd5
    } aluCtrl_e;

    typedef struct packed {
        logic     memtoreg;
        logic     regwrite;
        logic     memread;
        logic     memwrite;
        logic     branch;
        logic     jump;
        aluCtrl_e aluctr;
    } ctrl_t;

endpackage

// File: rtl/reg_file_2r1w.sv
// ---------------------------------------------------------------------------
// reg_file_2r1w
// NREG x XLEN register file with two combinational read ports and one
// synchronous write port. Entry 0 always reads as zero and ignores writes.
// A read of the entry being written this cycle returns the write data.
// Storage is deliberately not reset.
//   clk               clock
//   raddrA_i/rdataA_o read port A (index, data)
//   raddrB_i/rdataB_o read port B (index, data)
//   we_i, waddr_i, wdata_i  write port
// ---------------------------------------------------------------------------
module reg_file_2r1w
    import mips_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREG = NREG_DEFAULT
) (
    input  logic            clk,
    input  logic [4:0]      raddrA_i,
    output logic [XLEN-1:0] rdataA_o,
    input  logic [4:0]      raddrB_i,
    output logic [XLEN-1:0] rdataB_o,
    input  logic            we_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

    logic [XLEN-1:0] regs [NREG];
    logic [AW-1:0]   idxA, idxB, idxW;

    // Index bits above log2(NREG) are dropped, so aliased indices wrap.
    assign idxA = raddrA_i[AW-1:0];
    assign idxB = raddrB_i[AW-1:0];
    assign idxW = waddr_i[AW-1:0];

    always_ff @(posedge clk) begin
        if (we_i && (idxW != '0)) begin
            regs[idxW] <= wdata_i;
        end
    end

    // Bypass lets the decode stage see a value being written back this cycle.
    always_comb begin
        rdataA_o = regs[idxA];
        if (idxA == '0) begin
            rdataA_o = '0;
        end else if (we_i && (idxW == idxA)) begin
            rdataA_o = wdata_i;
        end
    end

    always_comb begin
        rdataB_o = regs[idxB];
        if (idxB == '0) begin
            rdataB_o = '0;
        end else if (we_i && (idxW == idxB)) begin
            rdataB_o = wdata_i;
        end
    end

endmodule

// File: rtl/pipe_decode_stage.sv
// ---------------------------------------------------------------------------
// pipe_decode_stage
// Instruction decode stage of a 5-stage MIPS-subset pipeline. Decodes if_ir,
// reads operands from the register file, detects load-use hazards and loads
// the DX pipeline register one cycle after acceptance.
//   clk, rst                      clock, async active-high reset
//   if_valid, if_pc, if_ir        incoming instruction
//   id_ready                      instruction accepted this cycle
//   ex_stall, flush               downstream hold / discard
//   wb_we, wb_rd, wb_data         register writeback
//   dx_*                          DX register contents
//   illegal                       one-cycle pulse for undefined encodings
//   hz_count                      saturating load-use stall counter
// ---------------------------------------------------------------------------
module pipe_decode_stage
    import mips_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREG = NREG_DEFAULT,
    parameter int CW   = CW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    input  logic [31:0]     if_ir,
    output logic            id_ready,
    input  logic            ex_stall,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            dx_valid,
    output logic            dx_memtoreg,
    output logic            dx_regwrite,
    output logic            dx_memread,
    output logic            dx_memwrite,
    output logic            dx_branch,
    output logic            dx_jump,
    output logic [2:0]      dx_aluctr,
    output logic [XLEN-1:0] dx_a,
    output logic [XLEN-1:0] dx_b,
    output logic [XLEN-1:0] dx_imm,
    output logic [XLEN-1:0] dx_pc,
    output logic [XLEN-1:0] dx_jt,
    output logic [4:0]      dx_rd,
    output logic [4:0]      dx_rt,
    output logic            illegal,
    output logic [CW-1:0]   hz_count
);

    typedef struct packed {
        logic            valid;
        ctrl_t           ctrl;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] jt;
        logic [4:0]      rd;
        logic [4:0]      rt;
    } dx_t;

    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
    localparam logic [4:0]      LINK_REG = 5'(NREG - 1);

    logic [5:0]      opcode, funct;
    logic [4:0]      rsIdx, rtIdx, rdIdx;
    logic [XLEN-1:0] rsVal, rtVal, simm, jumpTarget;
    dx_t             decoded, dx_d, dx_q;
    logic            legal, usesRt, loadUse;
    logic            illegal_d, illegal_q;
    logic [CW-1:0]   hzCount_d, hzCount_q;

    assign opcode = if_ir[31:26];
    assign rsIdx  = if_ir[25:21];
    assign rtIdx  = if_ir[20:16];
    assign rdIdx  = if_ir[15:11];
    assign funct  = if_ir[5:0];
    assign simm   = {{(XLEN-16){if_ir[15]}}, if_ir[15:0]};

    reg_file_2r1w #(.XLEN(XLEN), .NREG(NREG)) u_regFile (
        .clk      (clk),
        .raddrA_i (rsIdx),
        .rdataA_o (rsVal),
        .raddrB_i (rtIdx),
        .rdataB_o (rtVal),
        .we_i     (wb_we),
        .waddr_i  (wb_rd),
        .wdata_i  (wb_data)
    );

    // Pseudo-direct jump target; bits between the PC region and the 28-bit
    // field stay zero when XLEN is wider than 32.
    always_comb begin
        jumpTarget                  = '0;
        jumpTarget[XLEN-1:XLEN-4]   = if_pc[XLEN-1:XLEN-4];
        jumpTarget[27:0]            = {if_ir[25:0], 2'b00};
    end

    // Instruction decode. Fields not used by an instruction stay zero so a
    // decoded DX entry is fully determined by the instruction.
    always_comb begin
        decoded       = '0;
        decoded.valid = 1'b1;
        decoded.a     = rsVal;
        decoded.b     = rtVal;
        decoded.imm   = simm;
        decoded.pc    = if_pc;
        decoded.rt    = rtIdx;
        legal         = 1'b1;
        usesRt        = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                usesRt                   = 1'b1;
                decoded.ctrl.regwrite    = 1'b1;
                decoded.rd               = rdIdx;
                case (funct)
                    FN_ADD: decoded.ctrl.aluctr = ALU_ADD;
                    FN_SUB: decoded.ctrl.aluctr = ALU_SUB;
                    FN_AND: decoded.ctrl.aluctr = ALU_AND;
                    FN_OR:  decoded.ctrl.aluctr = ALU_OR;
                    FN_SLT: decoded.ctrl.aluctr = ALU_SLT;
                    FN_JR: begin
                        decoded.ctrl.regwrite = 1'b0;
                        decoded.rd            = '0;
                        decoded.ctrl.jump     = 1'b1;
                        decoded.ctrl.aluctr   = ALU_NONE;
                        decoded.jt            = rsVal;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_LW: begin
                decoded.ctrl.memread  = 1'b1;
                decoded.ctrl.memtoreg = 1'b1;
                decoded.ctrl.regwrite = 1'b1;
                decoded.ctrl.aluctr   = ALU_ADD;
                decoded.b             = simm;
                decoded.rd            = rtIdx;
            end
            OP_SW: begin
                usesRt                = 1'b1;
                decoded.ctrl.memwrite = 1'b1;
                decoded.ctrl.aluctr   = ALU_ADD;
                decoded.b             = simm;
            end
            OP_BEQ: begin
                usesRt                = 1'b1;
                decoded.ctrl.branch   = 1'b1;
                decoded.ctrl.aluctr   = ALU_NONE;
            end
            OP_J: begin
                decoded.ctrl.jump     = 1'b1;
                decoded.ctrl.aluctr   = ALU_NONE;
                decoded.jt            = jumpTarget;
            end
            OP_JAL: begin
                // Link value travels down the pipe as pc+4 through the ALU;
                // the register itself is written only at writeback.
                decoded.ctrl.jump     = 1'b1;
                decoded.ctrl.regwrite = 1'b1;
                decoded.ctrl.aluctr   = ALU_ADD;
                decoded.rd            = LINK_REG;
                decoded.a             = if_pc + PC_STEP;
                decoded.b             = '0;
                decoded.jt            = jumpTarget;
            end
            default: legal = 1'b0;
        endcase
    end

    // A load in DX cannot forward its data yet, so a dependent instruction
    // must wait one cycle.
    assign loadUse = if_valid && dx_q.valid && dx_q.ctrl.memread &&
                     (dx_q.rd != 5'd0) &&
                     ((dx_q.rd == rsIdx) || (usesRt && (dx_q.rd == rtIdx)));

    assign id_ready = flush || (!ex_stall && !loadUse);

    // DX update priority: flush, then downstream stall, then hazard bubble,
    // then normal decode (bubble for no/illegal instruction).
    always_comb begin
        dx_d      = dx_q;
        illegal_d = 1'b0;
        hzCount_d = hzCount_q;
        if (flush) begin
            dx_d = '0;
        end else if (ex_stall) begin
            dx_d = dx_q;
        end else if (loadUse) begin
            dx_d = '0;
            if (hzCount_q != '1) begin
                hzCount_d = hzCount_q + 1'b1;
            end
        end else if (if_valid && legal) begin
            dx_d = decoded;
        end else begin
            dx_d      = '0;
            illegal_d = if_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dx_q      <= '0;
            illegal_q <= 1'b0;
            hzCount_q <= '0;
        end else begin
            dx_q      <= dx_d;
            illegal_q <= illegal_d;
            hzCount_q <= hzCount_d;
        end
    end

    assign dx_valid    = dx_q.valid;
    assign dx_memtoreg = dx_q.ctrl.memtoreg;
    assign dx_regwrite = dx_q.ctrl.regwrite;
    assign dx_memread  = dx_q.ctrl.memread;
    assign dx_memwrite = dx_q.ctrl.memwrite;
    assign dx_branch   = dx_q.ctrl.branch;
    assign dx_jump     = dx_q.ctrl.jump;
    assign dx_aluctr   = dx_q.ctrl.aluctr;
    assign dx_a        = dx_q.a;
    assign dx_b        = dx_q.b;
    assign dx_imm      = dx_q.imm;
    assign dx_pc       = dx_q.pc;
    assign dx_jt       = dx_q.jt;
    assign dx_rd       = dx_q.rd;
    assign dx_rt       = dx_q.rt;
    assign illegal     = illegal_q;
    assign hz_count    = hzCount_q;

endmodule

// File: tb/tb_pipe_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_pipe_decode_stage
// Self-checking bench for pipe_decode_stage: directed scenarios followed by
// randomized instruction streams, all compared against a behavioural model.
// ---------------------------------------------------------------------------
module tb_pipe_decode_stage;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int CW   = 16;

    logic            clk, rst;
    logic            if_valid;
    logic [31:0]     if_pc, if_ir;
    logic            id_ready, ex_stall, flush;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [31:0]     wb_data;
    logic            dx_valid, dx_memtoreg, dx_regwrite, dx_memread;
    logic            dx_memwrite, dx_branch, dx_jump;
    logic [2:0]      dx_aluctr;
    logic [31:0]     dx_a, dx_b, dx_imm, dx_pc, dx_jt;
    logic [4:0]      dx_rd, dx_rt;
    logic            illegal;
    logic [CW-1:0]   hz_count;

    pipe_decode_stage #(.XLEN(XLEN), .NREG(NREG), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_ir       (if_ir),
        .id_ready    (id_ready),
        .ex_stall    (ex_stall),
        .flush       (flush),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .dx_valid    (dx_valid),
        .dx_memtoreg (dx_memtoreg),
        .dx_regwrite (dx_regwrite),
        .dx_memread  (dx_memread),
        .dx_memwrite (dx_memwrite),
        .dx_branch   (dx_branch),
        .dx_jump     (dx_jump),
        .dx_aluctr   (dx_aluctr),
        .dx_a        (dx_a),
        .dx_b        (dx_b),
        .dx_imm      (dx_imm),
        .dx_pc       (dx_pc),
        .dx_jt       (dx_jt),
        .dx_rd       (dx_rd),
        .dx_rt       (dx_rt),
        .illegal     (illegal),
        .hz_count    (hz_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference view of the DX register
    typedef struct {
        bit          valid, memtoreg, regwrite, memread, memwrite, branch, jump;
        int unsigned aluctr;
        logic [31:0] a, b, imm, pc, jt;
        int unsigned rd, rt;
    } dxModel_t;

    dxModel_t    mDx;
    bit          mIllegal;
    int unsigned mHz;
    logic [31:0] mRegs [32];
    int unsigned rFuncts [5] = '{32, 34, 36, 37, 42};
    int          checks;
    int          failures;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic dxModel_t emptyDx();
        dxModel_t d;
        d.valid = 0; d.memtoreg = 0; d.regwrite = 0; d.memread = 0;
        d.memwrite = 0; d.branch = 0; d.jump = 0; d.aluctr = 0;
        d.a = '0; d.b = '0; d.imm = '0; d.pc = '0; d.jt = '0;
        d.rd = 0; d.rt = 0;
        return d;
    endfunction

    // Architectural register read as the decode stage should see it
    function automatic logic [31:0] readReg(input int unsigned idx);
        if (idx == 0) return 32'd0;
        if (wb_we && (int'(wb_rd) == int'(idx))) return wb_data;
        return mRegs[idx];
    endfunction

    // Instruction semantics, written from the instruction-set table
    function automatic dxModel_t decodeModel(input logic [31:0] ir, input logic [31:0] pc,
                                             input logic [31:0] rsVal, input logic [31:0] rtVal,
                                             output bit legal);
        dxModel_t    d;
        int unsigned op, fn;
        logic [31:0] target;
        op     = int'(ir[31:26]);
        fn     = int'(ir[5:0]);
        target = {pc[31:28], ir[25:0], 2'b00};
        d      = emptyDx();
        d.valid = 1;
        d.pc    = pc;
        d.imm   = {{16{ir[15]}}, ir[15:0]};
        d.rt    = int'(ir[20:16]);
        d.a     = rsVal;
        d.b     = rtVal;
        legal   = 1;
        if (op == 0 && fn == 8) begin
            d.jump = 1; d.aluctr = 5; d.jt = rsVal;
        end else if (op == 0) begin
            legal = 0;
            for (int k = 0; k < 5; k++) begin
                if (fn == rFuncts[k]) begin
                    legal = 1; d.aluctr = k; d.regwrite = 1; d.rd = int'(ir[15:11]);
                end
            end
        end else if (op == 35) begin
            d.memread = 1; d.memtoreg = 1; d.regwrite = 1; d.rd = int'(ir[20:16]); d.b = d.imm;
        end else if (op == 43) begin
            d.memwrite = 1; d.b = d.imm;
        end else if (op == 4) begin
            d.branch = 1; d.aluctr = 5;
        end else if (op == 2) begin
            d.jump = 1; d.aluctr = 5; d.jt = target;
        end else if (op == 3) begin
            d.jump = 1; d.regwrite = 1; d.rd = NREG - 1;
            d.a = pc + 32'd4; d.b = 32'd0; d.jt = target;
        end else begin
            legal = 0;
        end
        return d;
    endfunction

    task automatic compareAll(input string where);
        checkOutput({where, ".dx_valid"},    32'(dx_valid),    32'(mDx.valid));
        checkOutput({where, ".dx_memtoreg"}, 32'(dx_memtoreg), 32'(mDx.memtoreg));
        checkOutput({where, ".dx_regwrite"}, 32'(dx_regwrite), 32'(mDx.regwrite));
        checkOutput({where, ".dx_memread"},  32'(dx_memread),  32'(mDx.memread));
        checkOutput({where, ".dx_memwrite"}, 32'(dx_memwrite), 32'(mDx.memwrite));
        checkOutput({where, ".dx_branch"},   32'(dx_branch),   32'(mDx.branch));
        checkOutput({where, ".dx_jump"},     32'(dx_jump),     32'(mDx.jump));
        checkOutput({where, ".dx_aluctr"},   32'(dx_aluctr),   mDx.aluctr);
        checkOutput({where, ".dx_a"},        dx_a,             mDx.a);
        checkOutput({where, ".dx_b"},        dx_b,             mDx.b);
        checkOutput({where, ".dx_imm"},      dx_imm,           mDx.imm);
        checkOutput({where, ".dx_pc"},       dx_pc,            mDx.pc);
        checkOutput({where, ".dx_jt"},       dx_jt,            mDx.jt);
        checkOutput({where, ".dx_rd"},       32'(dx_rd),       mDx.rd);
        checkOutput({where, ".dx_rt"},       32'(dx_rt),       mDx.rt);
        checkOutput({where, ".illegal"},     32'(illegal),     32'(mIllegal));
        checkOutput({where, ".hz_count"},    32'(hz_count),    mHz);
    endtask

    // One pipeline cycle: drive inputs, check id_ready, clock, check DX
    task automatic applyStimulus(input string where, input logic v, input logic [31:0] pc,
                                 input logic [31:0] ir, input logic st, input logic fl,
                                 input logic we, input logic [4:0] wrd, input logic [31:0] wdat);
        dxModel_t    decoded, nextDx;
        bit          legal, usesRt, loadUse, expReady, nextIllegal;
        int unsigned op, rs, rt;
        if_valid = v; if_pc = pc; if_ir = ir; ex_stall = st; flush = fl;
        wb_we = we; wb_rd = wrd; wb_data = wdat;
        #1;
        op      = int'(ir[31:26]);
        rs      = int'(ir[25:21]);
        rt      = int'(ir[20:16]);
        usesRt  = (op == 0) || (op == 4) || (op == 43);
        loadUse = v && mDx.valid && mDx.memread && (mDx.rd != 0) &&
                  ((mDx.rd == rs) || (usesRt && (mDx.rd == rt)));
        expReady = fl ? 1'b1 : ((st || loadUse) ? 1'b0 : 1'b1);
        checkOutput({where, ".id_ready"}, 32'(id_ready), 32'(expReady));
        decoded     = decodeModel(ir, pc, readReg(rs), readReg(rt), legal);
        nextIllegal = 0;
        if (fl)               nextDx = emptyDx();
        else if (st)          nextDx = mDx;
        else if (loadUse) begin
            nextDx = emptyDx();
            if (mHz < 65535) mHz++;
        end
        else if (!v)          nextDx = emptyDx();
        else if (!legal) begin
            nextDx = emptyDx(); nextIllegal = 1;
        end
        else                  nextDx = decoded;
        @(posedge clk);
        if (we && wrd != 5'd0) mRegs[wrd] = wdat;
        mDx      = nextDx;
        mIllegal = nextIllegal;
        #1;
        compareAll(where);
    endtask

    function automatic logic [31:0] randomInstr();
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [31:0] ir;
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        imm = 16'($urandom);
        case ($urandom_range(0, 9))
            0:       ir = {6'd0, rs, rt, rd, 5'd0, 6'(rFuncts[$urandom_range(0, 4)])};
            1:       ir = {6'd0, rs, 15'd0, 6'd8};
            2, 9:    ir = {6'd35, rs, rt, imm};
            3:       ir = {6'd43, rs, rt, imm};
            4:       ir = {6'd4, rs, rt, imm};
            5:       ir = {6'd2, 26'($urandom)};
            6:       ir = {6'd3, 26'($urandom)};
            7:       ir = $urandom;
            default: ir = {6'd0, rs, rt, rd, 5'd0, 6'($urandom)};
        endcase
        return ir;
    endfunction

    // Bound the run in case the clock or the flow ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        rv, rst_, rfl, rwe;
        logic [4:0]  rwrd;
        checks = 0; failures = 0;
        rst = 1'b0; if_valid = 1'b0; if_pc = '0; if_ir = '0;
        ex_stall = 1'b0; flush = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        mDx = emptyDx(); mIllegal = 0; mHz = 0;
        for (int i = 0; i < 32; i++) mRegs[i] = '0;

        // Asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #1 compareAll("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Load the register file through writeback with no instructions
        for (int i = 1; i < 32; i++) begin
            logic [31:0] val;
            val = (i == 1) ? 32'd5 : ((i == 2) ? 32'd7 : $urandom);
            applyStimulus("fill", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'(i), val);
        end

        // add r3,r1,r2
        applyStimulus("add", 1'b1, 32'h0040_0000, {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'd32},
                      1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        checkOutput("add.aluctr", 32'(dx_aluctr), 32'd0);
        checkOutput("add.a", dx_a, 32'd5);
        checkOutput("add.b", dx_b, 32'd7);
        checkOutput("add.rd", 32'(dx_rd), 32'd3);
        checkOutput("add.regwrite", 32'(dx_regwrite), 32'd1);

        // lw r4,8(r1) then dependent add r5,r4,r2; load data returns in the bubble
        applyStimulus("lw", 1'b1, 32'h0040_0004, {6'd35, 5'd1, 5'd4, 16'd8},
                      1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        applyStimulus("lu_stall", 1'b1, 32'h0040_0008, {6'd0, 5'd4, 5'd2, 5'd5, 5'd0, 6'd32},
                      1'b0, 1'b0, 1'b1, 5'd4, 32'h0000_1234);
        checkOutput("lu.bubble", 32'(dx_valid), 32'd0);
        checkOutput("lu.hz_count", 32'(hz_count), 32'd1);
        applyStimulus("lu_issue", 1'b1, 32'h0040_0008, {6'd0, 5'd4, 5'd2, 5'd5, 5'd0, 6'd32},
                      1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        checkOutput("lu.a", dx_a, 32'h0000_1234);
        checkOutput("lu.valid", 32'(dx_valid), 32'd1);

        // sub r6,r2,r0 with same-cycle writeback of r2
        applyStimulus("bypass", 1'b1, 32'h0040_000C, {6'd0, 5'd2, 5'd0, 5'd6, 5'd0, 6'd34},
                      1'b0, 1'b0, 1'b1, 5'd2, 32'h0000_00AA);
        checkOutput("bypass.a", dx_a, 32'h0000_00AA);
        checkOutput("bypass.b", dx_b, 32'd0);

        // beq, then three stall cycles with a flush in the second
        applyStimulus("beq", 1'b1, 32'h0040_0010, {6'd4, 5'd1, 5'd3, 16'h0010},
                      1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        applyStimulus("stall1", 1'b1, 32'h0040_0014, {6'd0, 5'd1, 5'd2, 5'd7, 5'd0, 6'd36},
                      1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        checkOutput("stall1.branch", 32'(dx_branch), 32'd1);
        checkOutput("stall1.a", dx_a, 32'd5);
        applyStimulus("stall2", 1'b1, 32'h0040_0014, {6'd0, 5'd1, 5'd2, 5'd7, 5'd0, 6'd36},
                      1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
        checkOutput("stall2.flushed", 32'(dx_valid), 32'd0);
        applyStimulus("stall3", 1'b1, 32'h0040_0018, {6'd0, 5'd1, 5'd2, 5'd7, 5'd0, 6'd36},
                      1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        checkOutput("stall3.valid", 32'(dx_valid), 32'd0);

        // jal 0x100 from 0x0040_0010
        applyStimulus("jal", 1'b1, 32'h0040_0010, {6'd3, 26'h100},
                      1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        checkOutput("jal.jt", dx_jt, 32'h0000_0400);
        checkOutput("jal.a", dx_a, 32'h0040_0014);
        checkOutput("jal.rd", 32'(dx_rd), 32'd31);
        checkOutput("jal.jump", 32'(dx_jump), 32'd1);

        // Undefined opcode pulses illegal for exactly one cycle
        applyStimulus("illegal", 1'b1, 32'h0040_0014, {6'h3F, 26'h0},
                      1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        checkOutput("illegal.pulse", 32'(illegal), 32'd1);
        checkOutput("illegal.valid", 32'(dx_valid), 32'd0);
        applyStimulus("after_illegal", 1'b1, 32'h0040_0018, {6'd35, 5'd2, 5'd9, 16'hFFF0},
                      1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        checkOutput("after_illegal.pulse", 32'(illegal), 32'd0);

        // Reset mid-stream, away from any clock edge
        if_valid = 1'b1;
        if_ir    = {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'd32};
        rst      = 1'b1;
        mDx = emptyDx(); mIllegal = 0; mHz = 0;
        #1 compareAll("rst_async");
        checkOutput("rst.valid", 32'(dx_valid), 32'd0);
        @(posedge clk);
        #1 compareAll("rst_hold");
        rst = 1'b0;
        #1 compareAll("rst_release");

        // Randomized streams
        for (int n = 0; n < 400; n++) begin
            rv   = 1'($urandom_range(0, 99) < 85);
            rst_ = 1'($urandom_range(0, 99) < 12);
            rfl  = 1'($urandom_range(0, 99) < 6);
            rwe  = 1'($urandom_range(0, 1));
            rwrd = 5'($urandom_range(0, 31));
            applyStimulus("rand", rv, $urandom & 32'hFFFF_FFFC, randomInstr(),
                          rst_, rfl, rwe, rwrd, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
